// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the fetch/prefetch stage: parameter defaults and counter sizing.
package fetch_pkg;

    localparam int DEF_PC_BITS    = 16;
    localparam int DEF_INSTR_BITS = 16;
    localparam int DEF_PC_INC     = 4;
    localparam int DEF_QDEPTH     = 4;
    localparam int DEF_RESET_PC   = 0;

    // Wrong-path responses can be owed by several back-to-back redirects.
    function automatic int drop_cnt_bits(input int qdepth);
        return $clog2(2 * qdepth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Redirect, instruction-memory and decode handshakes of the fetch stage.
interface fetch_prefetch_unit_if
    import fetch_pkg::*;
#(
    parameter int PC_BITS    = DEF_PC_BITS,
    parameter int INSTR_BITS = DEF_INSTR_BITS
);
    logic                  redirect_vld;
    logic [PC_BITS-1:0]    redirect_pc;
    logic                  mem_req_vld;
    logic [PC_BITS-1:0]    mem_req_addr;
    logic                  mem_req_rdy;
    logic                  mem_rsp_vld;
    logic [INSTR_BITS-1:0] mem_rsp_data;
    logic                  dec_vld;
    logic [PC_BITS-1:0]    dec_pc;
    logic [INSTR_BITS-1:0] dec_instr;
    logic                  dec_rdy;

    modport master (
        input  redirect_vld, redirect_pc, mem_req_rdy, mem_rsp_vld, mem_rsp_data, dec_rdy,
        output mem_req_vld, mem_req_addr, dec_vld, dec_pc, dec_instr
    );

    modport slave (
        output redirect_vld, redirect_pc, mem_req_rdy, mem_rsp_vld, mem_rsp_data, dec_rdy,
        input  mem_req_vld, mem_req_addr, dec_vld, dec_pc, dec_instr
    );
endinterface

// File: rtl/fetch_prefetch_unit_slot_queue.sv
// Circular slot buffer: slots are allocated at request, filled in order by responses,
// and freed from the head by decode. Wrap-bit pointers distinguish full from empty.
module fetch_slot_queue #(
    parameter int PC_BITS    = 16,
    parameter int INSTR_BITS = 16,
    parameter int QDEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [PC_BITS-1:0]       alloc_pc,
    input  logic                     fill,
    input  logic [INSTR_BITS-1:0]    fill_instr,
    input  logic                     deq,
    output logic [$clog2(QDEPTH):0]  occupancy,
    output logic [$clog2(QDEPTH):0]  unfilled,
    output logic                     head_filled,
    output logic [PC_BITS-1:0]       head_pc,
    output logic [INSTR_BITS-1:0]    head_instr
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] instr;
    } fetch_slot_t;

    fetch_slot_t      slots [QDEPTH];
    logic [PTR_W:0]   alloc_ptr, fill_ptr, head_ptr;

    // NOTE: slot storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (alloc) slots[alloc_ptr[PTR_W-1:0]].pc    <= alloc_pc;
        if (fill)  slots[fill_ptr[PTR_W-1:0]].instr  <= fill_instr;
    end

    // NOTE: sequential state uses non-blocking assignments so every pointer sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else if (flush) begin
            fill_ptr  <= alloc_ptr;
            head_ptr  <= alloc_ptr;
        end else begin
            if (alloc) alloc_ptr <= alloc_ptr + PTR_ONE;
            if (fill)  fill_ptr  <= fill_ptr + PTR_ONE;
            if (deq)   head_ptr  <= head_ptr + PTR_ONE;
        end
    end

    assign occupancy   = alloc_ptr - head_ptr;
    assign unfilled    = alloc_ptr - fill_ptr;
    assign head_filled = (fill_ptr != head_ptr);
    assign head_pc     = slots[head_ptr[PTR_W-1:0]].pc;
    assign head_instr  = slots[head_ptr[PTR_W-1:0]].instr;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: sequential PC generation, prefetch into a slot queue, and redirect flush
// with a count of wrong-path responses still owed by the memory.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_BITS    = DEF_PC_BITS,
    parameter int INSTR_BITS = DEF_INSTR_BITS,
    parameter int PC_INC     = DEF_PC_INC,
    parameter int QDEPTH     = DEF_QDEPTH,
    parameter int RESET_PC   = DEF_RESET_PC
) (
    input logic                  clk,
    input logic                  rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int CNT_W  = $clog2(QDEPTH) + 1;
    localparam int DROP_W = drop_cnt_bits(QDEPTH);

    logic [PC_BITS-1:0]    fetch_pc;
    logic [DROP_W-1:0]     drop_cnt;
    logic [CNT_W-1:0]      occupancy, unfilled;
    logic                  head_filled;
    logic [PC_BITS-1:0]    head_pc;
    logic [INSTR_BITS-1:0] head_instr;
    logic                  alloc, fill, deq, flush;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bus.mem_req_vld = 1'b0;
        bus.dec_vld     = 1'b0;
        if (!rst && !bus.redirect_vld) begin
            bus.mem_req_vld = (occupancy < CNT_W'(QDEPTH));
            bus.dec_vld     = head_filled;
        end
    end

    assign bus.mem_req_addr = fetch_pc;
    assign bus.dec_pc       = head_pc;
    assign bus.dec_instr    = head_instr;

    assign alloc = bus.mem_req_vld && bus.mem_req_rdy;
    assign deq   = bus.dec_vld && bus.dec_rdy;
    assign flush = !rst && bus.redirect_vld;
    // Responses owed to flushed requests are the oldest outstanding, so they are consumed first.
    assign fill  = !rst && !bus.redirect_vld && bus.mem_rsp_vld && (drop_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= PC_BITS'(RESET_PC);
            drop_cnt <= '0;
        end else if (bus.redirect_vld) begin
            fetch_pc <= bus.redirect_pc;
            drop_cnt <= drop_cnt + DROP_W'(unfilled) - DROP_W'(bus.mem_rsp_vld);
        end else begin
            if (alloc) fetch_pc <= fetch_pc + PC_BITS'(PC_INC);
            if (bus.mem_rsp_vld && drop_cnt != '0) drop_cnt <= drop_cnt - DROP_W'(1);
        end
    end

    fetch_slot_queue #(
        .PC_BITS   (PC_BITS),
        .INSTR_BITS(INSTR_BITS),
        .QDEPTH    (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc      (alloc),
        .alloc_pc   (fetch_pc),
        .fill       (fill),
        .fill_instr (bus.mem_rsp_data),
        .deq        (deq),
        .occupancy  (occupancy),
        .unfilled   (unfilled),
        .head_filled(head_filled),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) occupancy <= CNT_W'(QDEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) deq |-> head_filled);
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_vld |-> (drop_cnt != '0 || unfilled != '0));
    a_dec_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.dec_vld && !bus.dec_rdy) |=> (!bus.dec_vld || $stable({bus.dec_pc, bus.dec_instr})));
endmodule
